// File: rtl/parking_slot_manager_pkg.sv
// Shared types and helpers for the parking slot manager.
// PARKING_STATS_EN (optional) adds saturating statistics counters.
package parking_pkg;

  typedef enum logic [0:0] {
    DOOR_IDLE = 1'b0,
    DOOR_OPEN = 1'b1
  } door_state_e;

  localparam int unsigned STAT_W = 16;

  // Slot-index width; a 2-slot lot still needs one bit.
  function automatic int unsigned calc_slot_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parking_slot_manager_if.sv
// Sensor/driver bundle of the parking slot manager.
// PARKING_STATS_EN adds the stat_* counter outputs.
interface parking_slot_manager_if
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = calc_slot_w(NUM_SLOTS)
);

  logic                 entry_req;
  logic                 exit_req;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 entry_grant;
  logic [SLOT_W-1:0]    granted_slot;
  logic                 exit_ack;
  logic                 exit_err;
  logic                 door_open;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [SLOT_W:0]      occ_count;
  logic [SLOT_W-1:0]    best_slot;
  logic                 full;
  logic                 empty;
`ifdef PARKING_STATS_EN
  logic [STAT_W-1:0]    stat_entries;
  logic [STAT_W-1:0]    stat_rejects;
  logic [STAT_W-1:0]    stat_errors;

  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_grant, granted_slot, exit_ack, exit_err, door_open,
    input  occupancy, occ_count, best_slot, full, empty,
    input  stat_entries, stat_rejects, stat_errors
  );

  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_grant, granted_slot, exit_ack, exit_err, door_open,
    output occupancy, occ_count, best_slot, full, empty,
    output stat_entries, stat_rejects, stat_errors
  );
`else
  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_grant, granted_slot, exit_ack, exit_err, door_open,
    input  occupancy, occ_count, best_slot, full, empty
  );

  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_grant, granted_slot, exit_ack, exit_err, door_open,
    output occupancy, occ_count, best_slot, full, empty
  );
`endif

endinterface

// File: rtl/parking_slot_picker.sv
// Lowest-free-slot priority encoder over the occupancy bitmap.
module parking_slot_picker
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = calc_slot_w(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] i_occupancy,
  output logic [SLOT_W-1:0]    o_best_slot,
  output logic                 o_full,
  output logic                 o_empty
);

  // Scan downward so the lowest free index wins; stays 0 when full.
  always_comb begin
    o_best_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_occupancy[i]) o_best_slot = SLOT_W'(i);
    end
  end

  assign o_full  = &i_occupancy;
  assign o_empty = ~|i_occupancy;

endmodule

// File: rtl/parking_slot_manager.sv
// N-slot parking manager: occupancy bitmap, lowest-free slot assignment, timed door.
// PARKING_STATS_EN adds saturating entry/reject/error counters.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS        = 4,
  parameter int unsigned DOOR_HOLD_CYCLES = 8,
  parameter int unsigned SLOT_W           = calc_slot_w(NUM_SLOTS)
) (
  input logic                   clk,
  input logic                   reset,
  parking_slot_manager_if.slave io_bus
);

  localparam int unsigned CNT_W   = $clog2(DOOR_HOLD_CYCLES + 1);
  localparam logic [0:0]  ST_IDLE = DOOR_IDLE;
  localparam logic [0:0]  ST_OPEN = DOOR_OPEN;

  logic [NUM_SLOTS-1:0] r_occupancy, w_occ_d;
  logic [SLOT_W:0]      r_occ_count, w_count_d;
  logic [SLOT_W-1:0]    r_granted_slot, w_best_slot;
  logic                 r_entry_grant, r_exit_ack, r_exit_err;
  logic [0:0]           r_door_state, w_door_state_d;
  logic [CNT_W-1:0]     r_hold_cnt, w_hold_cnt_d;
  logic                 w_full, w_empty;
  logic                 w_entry_acc, w_exit_in_range, w_exit_ok, w_exit_bad, w_event;

  parking_slot_picker #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_picker (
    .i_occupancy (r_occupancy),
    .o_best_slot (w_best_slot),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_entry_acc     = io_bus.entry_req & ~w_full;
    w_exit_in_range = ({1'b0, io_bus.exit_slot} < (SLOT_W + 1)'(NUM_SLOTS));
    w_exit_ok       = io_bus.exit_req & w_exit_in_range & r_occupancy[io_bus.exit_slot];
    w_exit_bad      = io_bus.exit_req & ~w_exit_ok;
    w_event         = w_entry_acc | w_exit_ok;
  end

  // best_slot comes from the pre-exit bitmap, so a slot freed this cycle is never reused now.
  always_comb begin
    w_occ_d = r_occupancy;
    if (w_exit_ok)   w_occ_d[io_bus.exit_slot] = 1'b0;
    if (w_entry_acc) w_occ_d[w_best_slot]      = 1'b1;

    w_count_d = r_occ_count;
    case ({w_entry_acc, w_exit_ok})
      2'b10:   w_count_d = r_occ_count + (SLOT_W + 1)'(1);
      2'b01:   w_count_d = r_occ_count - (SLOT_W + 1)'(1);
      default: w_count_d = r_occ_count;
    endcase
  end

  always_comb begin
    w_door_state_d = r_door_state;
    w_hold_cnt_d   = r_hold_cnt;
    if (w_event) begin
      w_door_state_d = ST_OPEN;
      w_hold_cnt_d   = CNT_W'(DOOR_HOLD_CYCLES);
    end else if (r_door_state == ST_OPEN) begin
      if (r_hold_cnt <= CNT_W'(1)) begin
        w_door_state_d = ST_IDLE;
        w_hold_cnt_d   = '0;
      end else begin
        w_hold_cnt_d = r_hold_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occupancy    <= '0;
      r_occ_count    <= '0;
      r_entry_grant  <= 1'b0;
      r_granted_slot <= '0;
      r_exit_ack     <= 1'b0;
      r_exit_err     <= 1'b0;
      r_door_state   <= ST_IDLE;
      r_hold_cnt     <= '0;
    end else begin
      r_occupancy   <= w_occ_d;
      r_occ_count   <= w_count_d;
      r_entry_grant <= w_entry_acc;
      r_exit_ack    <= w_exit_ok;
      r_exit_err    <= w_exit_bad;
      r_door_state  <= w_door_state_d;
      r_hold_cnt    <= w_hold_cnt_d;
      if (w_entry_acc) r_granted_slot <= w_best_slot;
    end
  end

  assign io_bus.entry_grant  = r_entry_grant;
  assign io_bus.granted_slot = r_granted_slot;
  assign io_bus.exit_ack     = r_exit_ack;
  assign io_bus.exit_err     = r_exit_err;
  assign io_bus.door_open    = (r_door_state == ST_OPEN);
  assign io_bus.occupancy    = r_occupancy;
  assign io_bus.occ_count    = r_occ_count;
  assign io_bus.best_slot    = w_best_slot;
  assign io_bus.full         = w_full;
  assign io_bus.empty        = w_empty;

`ifdef PARKING_STATS_EN
  logic [STAT_W-1:0] r_stat_entries, r_stat_rejects, r_stat_errors;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_entries <= '0;
      r_stat_rejects <= '0;
      r_stat_errors  <= '0;
    end else begin
      if (w_entry_acc && (r_stat_entries != '1)) r_stat_entries <= r_stat_entries + 1'b1;
      if (io_bus.entry_req && w_full && (r_stat_rejects != '1)) begin
        r_stat_rejects <= r_stat_rejects + 1'b1;
      end
      if (w_exit_bad && (r_stat_errors != '1)) r_stat_errors <= r_stat_errors + 1'b1;
    end
  end

  assign io_bus.stat_entries = r_stat_entries;
  assign io_bus.stat_rejects = r_stat_rejects;
  assign io_bus.stat_errors  = r_stat_errors;
`endif

  a_count_matches_bitmap: assert property (@(posedge clk) disable iff (reset)
    r_occ_count == (SLOT_W + 1)'($countones(r_occupancy)));

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench for parking_slot_manager against a slot-array reference model.
module tb_parking_slot_manager;
  import parking_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned SW   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_slot_manager_if #(.NUM_SLOTS(N)) bus ();

  parking_slot_manager #(
    .NUM_SLOTS        (N),
    .DOOR_HOLD_CYCLES (HOLD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one flag per slot, plus the edge of the last door-opening event.
  bit          m_occ [N];
  int          m_edge = 0;
  int          m_last = -1000;
  logic        e_grant, e_ack, e_err;
  logic [SW-1:0] e_slot;

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_occ[i];
    return c;
  endfunction

  function automatic int m_best();
    for (int i = 0; i < N; i++) if (!m_occ[i]) return i;
    return 0;
  endfunction

  function automatic bit m_door();
    return (m_edge - m_last) < HOLD;
  endfunction

  task automatic tick();
    bit acc, ok;
    int best, xs;
    best = m_best();
    acc  = bus.entry_req && (m_cnt() < N);
    xs   = int'(bus.exit_slot);
    ok   = bus.exit_req && (xs < N) && m_occ[xs];
    e_grant = acc;
    e_ack   = ok;
    e_err   = bus.exit_req && !ok;
    if (acc) e_slot = SW'(best);
    if (ok)  m_occ[xs]   = 1'b0;
    if (acc) m_occ[best] = 1'b1;
    @(posedge clk);
    m_edge++;
    if (acc || ok) m_last = m_edge;
    #1;
  endtask

  task automatic set_in(input logic ent, input logic ex, input int slot);
    bus.entry_req = ent;
    bus.exit_req  = ex;
    bus.exit_slot = SW'(slot);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    m_last = -1000;
    e_grant = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_slot = '0;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.occupancy !== 4'b0000) begin n_fail++;
      $display("FAIL reset_occ: got %b want 0000", bus.occupancy); end
    n_cmp++; if (bus.occ_count !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", bus.occ_count); end
    n_cmp++; if ({bus.empty, bus.full, bus.best_slot} !== {1'b1, 1'b0, 2'd0}) begin n_fail++;
      $display("FAIL reset_flags: got e%b f%b b%0d want e1 f0 b0", bus.empty, bus.full,
               bus.best_slot); end
    n_cmp++;
    if ({bus.entry_grant, bus.exit_ack, bus.exit_err, bus.door_open} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b%b%b%b want 0000", bus.entry_grant, bus.exit_ack,
               bus.exit_err, bus.door_open); end
  endtask

  task automatic test_fill();
    do_reset();
    set_in(1'b1, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      n_cmp++; if (bus.entry_grant !== 1'b1 || bus.granted_slot !== SW'(i)) begin n_fail++;
        $display("FAIL fill_grant%0d: got g%b s%0d want g1 s%0d", i, bus.entry_grant,
                 bus.granted_slot, i); end
    end
    set_in(1'b0, 1'b0, 0);
    n_cmp++; if (bus.occupancy !== 4'b1111 || bus.full !== 1'b1 || bus.occ_count !== 3'd4)
    begin n_fail++;
      $display("FAIL fill_state: got occ %b full %b cnt %0d want 1111 1 4", bus.occupancy,
               bus.full, bus.occ_count); end
  endtask

  task automatic test_gap_refill();
    set_in(1'b0, 1'b1, 1);
    tick();
    n_cmp++; if (bus.exit_ack !== 1'b1 || bus.occupancy !== 4'b1101) begin n_fail++;
      $display("FAIL gap_exit: got ack %b occ %b want 1 1101", bus.exit_ack, bus.occupancy); end
    set_in(1'b1, 1'b0, 0);
    tick();
    set_in(1'b0, 1'b0, 0);
    n_cmp++;
    if (bus.entry_grant !== 1'b1 || bus.granted_slot !== 2'd1 || bus.occupancy !== 4'b1111)
    begin n_fail++;
      $display("FAIL gap_refill: got g%b s%0d occ %b want g1 s1 1111", bus.entry_grant,
               bus.granted_slot, bus.occupancy); end
  endtask

  task automatic test_invalid_exit();
    do_reset();
    set_in(1'b1, 1'b0, 0);
    repeat (3) tick();
    set_in(1'b0, 1'b1, 1);
    tick();
    set_in(1'b0, 1'b0, 0);
    repeat (HOLD + 2) tick();
    n_cmp++; if (bus.occupancy !== 4'b0101 || bus.door_open !== 1'b0) begin n_fail++;
      $display("FAIL inv_setup: got occ %b door %b want 0101 0", bus.occupancy,
               bus.door_open); end
    set_in(1'b0, 1'b1, 1);
    tick();
    set_in(1'b0, 1'b0, 0);
    n_cmp++;
    if (bus.exit_err !== 1'b1 || bus.exit_ack !== 1'b0 || bus.occupancy !== 4'b0101) begin
      n_fail++;
      $display("FAIL inv_exit: got err %b ack %b occ %b want 1 0 0101", bus.exit_err,
               bus.exit_ack, bus.occupancy); end
    tick();
    n_cmp++; if (bus.door_open !== 1'b0 || bus.exit_err !== 1'b0) begin n_fail++;
      $display("FAIL inv_door: got door %b err %b want 0 0", bus.door_open, bus.exit_err); end
  endtask

  task automatic test_simul_not_full();
    do_reset();
    set_in(1'b1, 1'b0, 0);
    repeat (2) tick();
    set_in(1'b1, 1'b1, 0);
    tick();
    set_in(1'b0, 1'b0, 0);
    n_cmp++;
    if (bus.entry_grant !== 1'b1 || bus.exit_ack !== 1'b1 || bus.granted_slot !== 2'd2 ||
        bus.occupancy !== 4'b0110 || bus.occ_count !== 3'd2) begin n_fail++;
      $display("FAIL simul_nf: got g%b a%b s%0d occ %b cnt %0d want g1 a1 s2 0110 2",
               bus.entry_grant, bus.exit_ack, bus.granted_slot, bus.occupancy,
               bus.occ_count); end
  endtask

  task automatic test_simul_full();
    do_reset();
    set_in(1'b1, 1'b0, 0);
    repeat (4) tick();
    set_in(1'b1, 1'b1, 2);
    tick();
    n_cmp++; if (bus.exit_ack !== 1'b1 || bus.entry_grant !== 1'b0) begin n_fail++;
      $display("FAIL simul_full_c1: got ack %b grant %b want 1 0", bus.exit_ack,
               bus.entry_grant); end
    set_in(1'b1, 1'b0, 0);
    tick();
    set_in(1'b0, 1'b0, 0);
    n_cmp++; if (bus.entry_grant !== 1'b1 || bus.granted_slot !== 2'd2) begin n_fail++;
      $display("FAIL simul_full_c2: got g%b s%0d want g1 s2", bus.entry_grant,
               bus.granted_slot); end
  endtask

  task automatic test_door();
    int high;
    do_reset();
    high = 0;
    set_in(1'b1, 1'b0, 0);
    tick(); high += bus.door_open;
    set_in(1'b0, 1'b0, 0);
    repeat (24) begin tick(); high += bus.door_open; end
    n_cmp++; if (high !== HOLD) begin n_fail++;
      $display("FAIL door_single: got %0d cycles want %0d", high, HOLD); end

    do_reset();
    high = 0;
    set_in(1'b1, 1'b0, 0);
    tick(); high += bus.door_open;
    set_in(1'b0, 1'b0, 0);
    repeat (4) begin tick(); high += bus.door_open; end
    set_in(1'b0, 1'b1, 0);
    tick(); high += bus.door_open;
    set_in(1'b0, 1'b0, 0);
    repeat (20) begin tick(); high += bus.door_open; end
    n_cmp++; if (high !== 13) begin n_fail++;
      $display("FAIL door_extend: got %0d cycles want 13", high); end

    do_reset();
    set_in(1'b1, 1'b0, 0);
    tick();
    set_in(1'b0, 1'b0, 0);
    repeat (2) tick();
    n_cmp++; if (bus.door_open !== 1'b1) begin n_fail++;
      $display("FAIL door_pre_reset: got %b want 1", bus.door_open); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.door_open !== 1'b0 || bus.occupancy !== 4'b0000) begin n_fail++;
      $display("FAIL door_async_reset: got door %b occ %b want 0 0000", bus.door_open,
               bus.occupancy); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), $urandom_range(0, N - 1));
      tick();
      n_cmp++;
      if (bus.entry_grant !== e_grant || bus.exit_ack !== e_ack || bus.exit_err !== e_err)
      begin n_fail++;
        $display("FAIL rnd_pulses c%0d: got g%b a%b e%b want g%b a%b e%b", c, bus.entry_grant,
                 bus.exit_ack, bus.exit_err, e_grant, e_ack, e_err); end
      if (e_grant) begin
        n_cmp++; if (bus.granted_slot !== e_slot) begin n_fail++;
          $display("FAIL rnd_slot c%0d: got %0d want %0d", c, bus.granted_slot, e_slot); end
      end
      n_cmp++;
      if (bus.occupancy !== m_vec() || bus.occ_count !== 3'(m_cnt())) begin n_fail++;
        $display("FAIL rnd_occ c%0d: got %b/%0d want %b/%0d", c, bus.occupancy,
                 bus.occ_count, m_vec(), m_cnt()); end
      n_cmp++;
      if (bus.full !== (m_cnt() == N) || bus.empty !== (m_cnt() == 0) ||
          bus.best_slot !== SW'(m_best())) begin n_fail++;
        $display("FAIL rnd_flags c%0d: got f%b e%b b%0d want f%b e%b b%0d", c, bus.full,
                 bus.empty, bus.best_slot, (m_cnt() == N), (m_cnt() == 0), m_best()); end
      n_cmp++; if (bus.door_open !== m_door()) begin n_fail++;
        $display("FAIL rnd_door c%0d: got %b want %b", c, bus.door_open, m_door()); end
    end
    set_in(1'b0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 0);
    #12;
    test_reset();
    test_fill();
    test_gap_refill();
    test_invalid_exit();
    test_simul_not_full();
    test_simul_full();
    test_door();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
